// File: rtl/hitmark_pkg.sv
// Shared types and constants for the hitmark sprite sequencer.
package hitmark_pkg;

    typedef enum logic [1:0] {IDLE, ARM, ANIM, BLINK} hm_state_t;

    localparam logic [10:0] OFFSCREEN = 11'h7ff;
    localparam int          SPR_SIZE  = 16;

    // Sprite ctrl word layout: {kind[1:0], auto, sid[1:0]}
    typedef struct packed {
        logic [1:0] kind;
        logic       auto_en;
        logic [1:0] sid;
    } hm_ctrl_t;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame-start strobe from the raster counters, matching the sprite engine's rule.
module frame_tick_gen #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         ft
);

    logic [W-1:0] x_d1;

    always_ff @(posedge clk) begin
        if (!reset_n) x_d1 <= '0;
        else          x_d1 <= x;
    end

    assign ft = (x_d1 == '0) && (x == W'(1)) && (y == '0);

endmodule

// File: rtl/hitmark_ctrl.sv
// Hit-event sequencer: positions the hitmark sprite, animates, blinks, then hides it.
module hitmark_ctrl #(
    parameter int          FRAME_HOLD = 4,
    parameter int          N_BLINK    = 3,
    parameter int          H_MAX      = 640,
    parameter int          V_MAX      = 480,
    parameter int          SPR_SIZE   = hitmark_pkg::SPR_SIZE,
    parameter logic [10:0] OFFSCREEN  = hitmark_pkg::OFFSCREEN
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        hit_valid,
    output logic        hit_ready,
    input  logic [10:0] hit_x,
    input  logic [10:0] hit_y,
    input  logic [1:0]  hit_kind,
    output logic [10:0] x0,
    output logic [10:0] y0,
    output logic [4:0]  ctrl,
    output logic        busy,
    output logic        done
);
    import hitmark_pkg::*;

    localparam int FW = $clog2(FRAME_HOLD) + 1;
    localparam int BW = $clog2(2 * N_BLINK) + 1;
    localparam logic [FW-1:0]     F_LAST = FW'(FRAME_HOLD - 1);
    localparam logic [BW-1:0]     B_LAST = BW'((N_BLINK > 0) ? 2 * N_BLINK - 1 : 0);
    localparam logic signed [11:0] HALF  = 12'(SPR_SIZE / 2);
    localparam logic signed [11:0] X_LIM = 12'(H_MAX - SPR_SIZE);
    localparam logic signed [11:0] Y_LIM = 12'(V_MAX - SPR_SIZE);

    hm_state_t         state, state_n;
    hm_ctrl_t          ctrl_q;
    logic              ft, accept, phase_end;
    logic [10:0]       ox, oy, ox_n, oy_n;
    logic [1:0]        kind_c;
    logic [FW-1:0]     fcnt;
    logic [BW-1:0]     bcnt;
    logic signed [11:0] cx, cy;

    frame_tick_gen #(.W(11)) u_ftg (
        .clk     (clk),
        .reset_n (reset_n),
        .x       (x),
        .y       (y),
        .ft      (ft)
    );

    assign hit_ready = (state != ARM);
    assign busy      = (state != IDLE);
    assign accept    = hit_valid && hit_ready;
    assign phase_end = ft && (fcnt == F_LAST);
    assign ctrl      = ctrl_q;

    // Centre-to-origin conversion, clamped so the whole sprite stays on screen
    always_comb begin
        cx = $signed({1'b0, hit_x}) - HALF;
        cy = $signed({1'b0, hit_y}) - HALF;
        if (cx < 12'sd0)      ox_n = '0;
        else if (cx > X_LIM)  ox_n = X_LIM[10:0];
        else                  ox_n = cx[10:0];
        if (cy < 12'sd0)      oy_n = '0;
        else if (cy > Y_LIM)  oy_n = Y_LIM[10:0];
        else                  oy_n = cy[10:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // A new hit always wins over a coincident frame tick
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (accept) state_n = ARM;
            ARM:   if (ft) state_n = ANIM;
            ANIM:  if (accept) state_n = ARM;
                   else if (phase_end && ctrl_q.sid == 2'd3)
                       state_n = (N_BLINK == 0) ? IDLE : BLINK;
            BLINK: if (accept) state_n = ARM;
                   else if (phase_end && bcnt == B_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x0     <= OFFSCREEN;
            y0     <= OFFSCREEN;
            ctrl_q <= '0;
            ox     <= '0;
            oy     <= '0;
            kind_c <= '0;
            fcnt   <= '0;
            bcnt   <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                ox     <= ox_n;
                oy     <= oy_n;
                kind_c <= hit_kind;
            end
            if (ft && !accept) begin
                unique case (state)
                    ARM: begin
                        x0     <= ox;
                        y0     <= oy;
                        ctrl_q <= '{kind: kind_c, auto_en: 1'b0, sid: 2'd0};
                        fcnt   <= '0;
                    end
                    ANIM: begin
                        if (fcnt != F_LAST) begin
                            fcnt <= fcnt + 1'b1;
                        end else begin
                            fcnt <= '0;
                            if (ctrl_q.sid != 2'd3) begin
                                ctrl_q.sid <= ctrl_q.sid + 2'd1;
                            end else begin
                                // Both exits (to BLINK phase 0 or to IDLE) hide the sprite
                                x0   <= OFFSCREEN;
                                y0   <= OFFSCREEN;
                                bcnt <= '0;
                                done <= (N_BLINK == 0);
                            end
                        end
                    end
                    BLINK: begin
                        if (fcnt != F_LAST) begin
                            fcnt <= fcnt + 1'b1;
                        end else begin
                            fcnt <= '0;
                            if (bcnt == B_LAST) begin
                                x0   <= OFFSCREEN;
                                y0   <= OFFSCREEN;
                                done <= 1'b1;
                            end else begin
                                bcnt <= bcnt + 1'b1;
                                x0   <= bcnt[0] ? OFFSCREEN : ox;
                                y0   <= bcnt[0] ? OFFSCREEN : oy;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hitmark_ctrl.sv
// Bench for hitmark_ctrl on a shrunken 8x2 raster (16 cycles per frame).
module tb_hitmark_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] x, y, hit_x, hit_y, x0, y0;
    logic        hit_valid, hit_ready, busy, done;
    logic [1:0]  hit_kind;
    logic [4:0]  ctrl;

    int errors = 0;
    int checks = 0;
    int pos    = 0;

    typedef struct {
        logic [10:0] x0;
        logic [10:0] y0;
        logic [4:0]  ctrl;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [10:0] hx;
        logic [10:0] hy;
        logic [1:0]  k;
        logic [10:0] ex;
        logic [10:0] ey;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    hitmark_ctrl #(.FRAME_HOLD(2), .N_BLINK(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .x         (x),
        .y         (y),
        .hit_valid (hit_valid),
        .hit_ready (hit_ready),
        .hit_x     (hit_x),
        .hit_y     (hit_y),
        .hit_kind  (hit_kind),
        .x0        (x0),
        .y0        (y0),
        .ctrl      (ctrl),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // One clock; raster advances and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
        pos = (pos + 1) % 16;
        x   = 11'(pos % 8);
        y   = 11'(pos / 8);
    endtask

    // Run up to and through the next frame-tick edge
    task automatic next_frame();
        int n = 0;
        while (pos != 1 && n < 40) begin
            step();
            n++;
        end
        if (pos != 1) chk("frame_timeout", 0, 1);
        step();
    endtask

    task automatic to_pos(input int p);
        int n = 0;
        while (pos != p && n < 40) begin
            step();
            n++;
        end
        if (pos != p) chk("pos_timeout", 0, 1);
    endtask

    task automatic do_hit(input logic [10:0] hx, input logic [10:0] hy, input logic [1:0] k,
                          input logic [10:0] ex, input logic [10:0] ey);
        exp_t e;
        e.x0 = ex;
        e.y0 = ey;
        e.ctrl = {k, 1'b0, 2'b00};
        sb.push_back(e);
        hit_x = hx;
        hit_y = hy;
        hit_kind = k;
        hit_valid = 1'b1;
        chk("hit_ready_at_accept", hit_ready, 1);
        step();
        hit_valid = 1'b0;
        chk("arm_busy", busy, 1);
        chk("arm_ready", hit_ready, 0);
    endtask

    task automatic sb_pop(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            chk({name, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({name, "_x0"}, x0, e.x0);
            chk({name, "_y0"}, y0, e.y0);
            chk({name, "_ctrl"}, ctrl, e.ctrl);
        end
    endtask

    task automatic do_reset();
        hit_valid = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("rst_x0", x0, 11'h7ff);
        chk("rst_y0", y0, 11'h7ff);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", hit_ready, 1);
        chk("rst_done", done, 0);
    endtask

    // Full sequence after the origin frame (f0): FH=2, N_BLINK=1 -> done at frame 12
    task automatic run_seq(input string name, input logic [10:0] vx);
        for (int f = 1; f <= 12; f++) begin
            next_frame();
            if (f < 12) begin
                chk($sformatf("%s_f%0d_x0", name, f), x0, (f == 8 || f == 9) ? 11'h7ff : vx);
                chk($sformatf("%s_f%0d_sid", name, f), ctrl[1:0], (f < 8) ? f / 2 : 3);
                chk($sformatf("%s_f%0d_done", name, f), done, 0);
                chk($sformatf("%s_f%0d_busy", name, f), busy, 1);
            end else begin
                chk($sformatf("%s_end_done", name), done, 1);
                chk($sformatf("%s_end_x0", name), x0, 11'h7ff);
                chk($sformatf("%s_end_busy", name), busy, 0);
                chk($sformatf("%s_end_ready", name), hit_ready, 1);
            end
        end
        step();
        chk({name, "_done_one_cycle"}, done, 0);
    endtask

    initial begin
        vecs[0] = '{hx: 100, hy: 200, k: 2, ex: 92,  ey: 192};
        vecs[1] = '{hx: 3,   hy: 479, k: 1, ex: 0,   ey: 464};
        vecs[2] = '{hx: 639, hy: 5,   k: 3, ex: 624, ey: 0};
        vecs[3] = '{hx: 8,   hy: 8,   k: 0, ex: 0,   ey: 0};
        vecs[4] = '{hx: 7,   hy: 0,   k: 1, ex: 0,   ey: 0};
        vecs[5] = '{hx: 632, hy: 472, k: 2, ex: 624, ey: 464};
        vecs[6] = '{hx: 631, hy: 471, k: 3, ex: 623, ey: 463};

        x = 0; y = 0;
        hit_x = 0; hit_y = 0; hit_kind = 0; hit_valid = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        chk("init_x0", x0, 11'h7ff);
        chk("init_y0", y0, 11'h7ff);
        chk("init_ctrl", ctrl, 0);
        chk("init_busy", busy, 0);
        chk("init_ready", hit_ready, 1);
        chk("init_done", done, 0);

        // Basic hit and full animation/blink sequence
        do_hit(100, 200, 2, 92, 192);
        next_frame();
        sb_pop("basic");
        run_seq("basic", 92);

        // Clamp table: origin at first frame tick, then reset
        foreach (vecs[i]) begin
            do_hit(vecs[i].hx, vecs[i].hy, vecs[i].k, vecs[i].ex, vecs[i].ey);
            next_frame();
            sb_pop($sformatf("vec%0d", i));
            do_reset();
        end

        // Reset in the middle of the hidden blink phase
        do_hit(100, 200, 2, 92, 192);
        next_frame();
        sb_pop("midblink");
        for (int f = 1; f <= 8; f++) next_frame();
        chk("midblink_busy", busy, 1);
        chk("midblink_hidden", x0, 11'h7ff);
        do_reset();
        for (int f = 0; f < 3; f++) begin
            next_frame();
            chk($sformatf("postrst_f%0d_done", f), done, 0);
            chk($sformatf("postrst_f%0d_busy", f), busy, 0);
            chk($sformatf("postrst_f%0d_x0", f), x0, 11'h7ff);
        end

        // Retrigger during animation at sid=2
        do_hit(100, 200, 2, 92, 192);
        next_frame();
        sb_pop("retrigA");
        for (int f = 1; f <= 4; f++) next_frame();
        chk("retrig_sid2", ctrl, 5'b10010);
        do_hit(300, 100, 1, 292, 92);
        chk("retrig_hold_x0", x0, 92);
        chk("retrig_hold_ctrl", ctrl, 5'b10010);
        next_frame();
        sb_pop("retrigB");
        run_seq("retrigB", 292);

        // Accept on the same cycle as a frame tick in BLINK
        do_hit(200, 300, 0, 192, 292);
        next_frame();
        sb_pop("coincA");
        for (int f = 1; f <= 9; f++) next_frame();
        chk("coinc_pre_hidden", x0, 11'h7ff);
        to_pos(1);
        do_hit(50, 60, 3, 42, 52);
        chk("coinc_x0_hold", x0, 11'h7ff);
        chk("coinc_done", done, 0);
        next_frame();
        sb_pop("coincB");
        do_reset();

        // Backpressure in ARM: changing hit_x must be ignored
        to_pos(3);
        do_hit(400, 400, 1, 392, 392);
        for (int j = 0; j < 3; j++) begin
            hit_valid = 1'b1;
            hit_x = 11'(100 + j * 50);
            chk($sformatf("bp_ready_%0d", j), hit_ready, 0);
            step();
        end
        hit_valid = 1'b0;
        next_frame();
        sb_pop("bp");
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hitmark_ctrl.md
# hitmark_ctrl

Sequencer for the hitmark sprite engine. It accepts hit events from game logic and positions the sprite on the next frame boundary. It steps the sprite through its four animation frames, blinks it, then hides it. It drives the sprite's `x0`, `y0` and `ctrl` inputs, sits between the game FSM and the hitmark sprite, and watches the same scan counters the sprite uses.

## Interface
Parameters:
- `FRAME_HOLD`, 4: video frames each animation/blink phase lasts (≥1)
- `N_BLINK`, 3: number of hidden/visible blink pairs after the animation (≥0)
- `H_MAX`, 640: visible width; `V_MAX`, 480: visible height
- `SPR_SIZE`, 16: sprite edge in pixels
- `OFFSCREEN`, 11'h7ff: origin value that places the sprite out of region

Ports:
- `clk` in 1: system clock
- `reset_n` in 1: synchronous, active-low reset
- `x`, `y` in 11 each: current scan coordinates
- `hit_valid` in 1: hit event request
- `hit_ready` out 1: controller can accept a hit
- `hit_x`, `hit_y` in 11 each: hit centre, in pixels
- `hit_kind` in 2: colour select, forwarded to `ctrl[4:3]`
- `x0`, `y0` out 11 each: sprite origin
- `ctrl` out 5: `{kind[1:0], auto=0, sid[1:0]}`
- `busy` out 1: not in IDLE
- `done` out 1: one-cycle pulse when a sequence completes

## Operation
- Frame tick: `ft = (x_d1==0) && (x==1) && (y==0)`, with `x_d1` registered `x`. This is the same rule as the sprite engine.
- `auto` is always 0. The controller owns `sid`.
- Accept: `hit_valid && hit_ready`.
  - Capture `ox = min(max(hit_x - SPR_SIZE/2, 0), H_MAX - SPR_SIZE)`, computed signed 12-bit. Compute `oy` the same way with `V_MAX`.
  - Capture `hit_kind`.
- FSM states:
  - IDLE: `hit_ready=1`. On accept, go to ARM.
  - ARM: `hit_ready=0`. On `ft`, go to ANIM:
    - `x0/y0 <= ox/oy`
    - `sid <= 0`
    - `fcnt <= 0`
  - ANIM: `hit_ready=1`. On each `ft`, `fcnt++`. When `fcnt` reaches `FRAME_HOLD-1`:
    - `fcnt <= 0`
    - if `sid` is 3, go to BLINK with `bcnt <= 0`; otherwise `sid++`
  - BLINK: `hit_ready=1`. The phase index is `bcnt`, range `0..2*N_BLINK-1`.
    - Even phase: `x0 = OFFSCREEN`, `y0 = OFFSCREEN`.
    - Odd phase: origin restored, `sid` held at 3.
    - Each phase lasts `FRAME_HOLD` frames.
    - After the last phase ends on `ft`: go to IDLE, `x0 = y0 = OFFSCREEN`, `done` pulses.
  - If `N_BLINK=0`, ANIM goes directly to the IDLE exit action.
- Retrigger: an accept in ANIM or BLINK captures the new `ox/oy/kind` and goes to ARM. The old sprite stays displayed until the next `ft`. No `done` is produced for the aborted sequence.
- Simultaneous `ft` and accept in ANIM/BLINK: the accept wins, so the state goes to ARM. The new origin is applied at the following `ft`, not the same one.
- `x0`, `y0` and `ctrl` change only on `ft` edges (no mid-frame tearing). The exception is reset.

## Timing
- Reset (`reset_n=0` at a clk edge), from any state, including mid-sequence:
  - state IDLE
  - `x0 = y0 = OFFSCREEN`
  - `ctrl = 0`
  - `busy = 0`, `done = 0`
  - `hit_ready = 1` combinationally after the reset edge
  - `x_d1 = 0`, all counters 0
- All outputs are registered except `hit_ready` and `busy`, which decode the state register.
- Accept to visible origin: the first `ft` after the accept cycle, with outputs valid the cycle after that `ft`.
- Sequence length from the ARM→ANIM `ft`: `(4 + 2*N_BLINK) * FRAME_HOLD` frames until IDLE.
- `done` is high for exactly one cycle, on the same edge as the IDLE transition.
- `fcnt` width is `$clog2(FRAME_HOLD)+1`. `bcnt` width is `$clog2(2*N_BLINK)+1`. No wrap-around occurs in normal operation; counters reset to 0 at each phase change.

## Structure
- Package `hitmark_pkg`:
  - `typedef enum logic [1:0] {IDLE, ARM, ANIM, BLINK} hm_state_t`
  - `OFFSCREEN`
  - `SPR_SIZE`
  - the ctrl field positions
- Sub-module `frame_tick_gen`: the `x_d1` register plus the `ft` decode. It is reusable by other sprite controllers.
- The clamp arithmetic is inline combinational logic.

## Test plan
- Reset mid-BLINK: assert `reset_n=0` for 1 cycle → `x0=y0=0x7ff`, `ctrl=0`, `busy=0`, `hit_ready=1`, no `done`.
- Basic hit (`FRAME_HOLD=2`, `N_BLINK=1`): `hit_x=100`, `hit_y=200`, `kind=2` →
  - at the first `ft`: `x0=92`, `y0=192`, `ctrl=5'b10000`
  - `sid` steps 0,1,2,3 every 2 frames
  - then hidden for 2 frames, visible for 2 frames
  - `done` pulses at frame 12
- Clamp: `hit_x=3`, `hit_y=479` → `x0=0`, `y0=464`. Separately, `hit_x=639` → `x0=624`.
- Retrigger in ANIM at `sid=2` with `hit_x=300` → old origin holds until the next `ft`. Then `x0=292`, `sid=0`, and no `done` for the first hit.
- Accept coinciding with `ft` in BLINK → state ARM. The new origin appears one `ft` later, not on the coincident `ft`.
- ARM backpressure: hold `hit_valid=1` with a changing `hit_x` during ARM → `hit_ready=0` and the first captured value is kept.
